// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver with a 2-flop input synchronizer.
//
// Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); line idles high.
// Bits are sampled at their nominal centre. The first sample is taken HALF
// cycles after the falling edge seen on the synchronized line, and each later
// sample follows CLKS_PER_BIT cycles after the one before it.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (4..8191)
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   rx_i         asynchronous serial input
//   data_o       last correctly framed byte; changes only with valid_o
//   valid_o      one-cycle pulse, data_o holds a new byte
//   frame_err_o  one-cycle pulse, stop bit sampled low
//   active_o     high while a frame is being received
module uart_rx #(
  parameter logic [12:0] CLKS_PER_BIT = 13'd1736
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       active_o
);

  localparam logic [12:0] HALF      = CLKS_PER_BIT / 13'd2;
  localparam logic [12:0] HALF_LAST = HALF - 13'd1;
  localparam logic [12:0] BIT_LAST  = CLKS_PER_BIT - 13'd1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START_B = 3'd1,
    DATA    = 3'd2,
    STOP_B  = 3'd3,
    CLEANUP = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        active_q, active_d;
  logic        rx_meta_q, rx_s_q;

  // Synchronizer resets to the idle level so a reset never looks like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) state_d = START_B;
      end

      START_B: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          // A start bit that is gone by mid-bit was a glitch: drop it silently.
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = STOP_B;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end

      STOP_B: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = CLEANUP;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end

      CLEANUP: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Registered so active_o tracks the state register without decode glitches.
    active_d = (state_d == START_B) || (state_d == DATA) || (state_d == STOP_B);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      active_q <= active_d;
    end
  end

  // NOTE: the shift register is pure datapath; it is only copied to data_o after
  // all eight bits of a good frame have been written, so it needs no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign active_o    = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed self-checking bench for uart_rx with CLKS_PER_BIT=16.
// Inputs are driven and outputs sampled on the falling clock edge. A monitor
// counts pulses, logs received bytes and active cycles; directed frames are
// then checked against hand-computed expectations.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       active_o;

  uart_rx #(.CLKS_PER_BIT(13'd16)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .active_o    (active_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Monitor
  int         valid_cnt = 0;
  int         ferr_cnt  = 0;
  int         act_cyc   = 0;
  int         both_cnt  = 0;
  int         data_bad  = 0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) begin
        valid_cnt++;
        rx_log.push_back(data_o);
      end
      if (frame_err_o) ferr_cnt++;
      if (valid_o && frame_err_o) both_cnt++;
      if (active_o) act_cyc++;
      if (!valid_o && data_o !== prev_data) data_bad++;
    end
    prev_data = data_o;
  end

  function automatic logic [7:0] last_byte(input int back);
    if (rx_log.size() > back) return rx_log[rx_log.size() - 1 - back];
    return 8'hxx;
  endfunction

  task automatic hold(input logic v, input int n);
    rx_i = v;
    repeat (n) @(negedge clk);
  endtask

  // Boundary k (between bit k-1 and bit k) is shifted by +/-jit, alternating.
  function automatic int boundary_off(input int k, input int jit);
    if (k <= 0 || k >= 10) return 0;
    return (k % 2 == 1) ? jit : -jit;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int jit);
    logic [9:0] bits;
    bits = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++)
      hold(bits[i], CPB + boundary_off(i + 1, jit) - boundary_off(i, jit));
  endtask

  int v0, f0, a0;

  initial begin
    rst  = 1'b1;
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data",   data_o,      8'h00);
    check("rst_valid",  valid_o,     1'b0);
    check("rst_ferr",   frame_err_o, 1'b0);
    check("rst_active", active_o,    1'b0);
    rst = 1'b0;
    hold(1'b1, 20);

    // Clean frame 0xA5: active for HALF + 8*CPB + CPB = 152 cycles.
    v0 = valid_cnt; f0 = ferr_cnt; a0 = act_cyc;
    send_frame(8'hA5, 1'b1, 0);
    hold(1'b1, 40);
    check("a5_valid_n",  valid_cnt - v0, 1);
    check("a5_ferr_n",   ferr_cnt - f0,  0);
    check("a5_byte",     last_byte(0),   8'hA5);
    check("a5_data",     data_o,         8'hA5);
    check("a5_act_cyc",  act_cyc - a0,   152);
    check("a5_active",   active_o,       1'b0);

    // 4-cycle glitch: START_B for HALF = 8 cycles, then back to IDLE.
    v0 = valid_cnt; f0 = ferr_cnt; a0 = act_cyc;
    hold(1'b0, 4);
    hold(1'b1, 40);
    check("gl_act_cyc", act_cyc - a0,   8);
    check("gl_valid_n", valid_cnt - v0, 0);
    check("gl_ferr_n",  ferr_cnt - f0,  0);
    check("gl_data",    data_o,         8'hA5);

    // 0x3C with a low stop bit.
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 0);
    hold(1'b1, 40);
    check("fe_ferr_n",  ferr_cnt - f0,  1);
    check("fe_valid_n", valid_cnt - v0, 0);
    check("fe_data",    data_o,         8'hA5);

    // Back-to-back 0x00, 0xFF.
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    hold(1'b1, 40);
    check("b2b_valid_n", valid_cnt - v0, 2);
    check("b2b_ferr_n",  ferr_cnt - f0,  0);
    check("b2b_first",   last_byte(1),   8'h00);
    check("b2b_second",  last_byte(0),   8'hFF);
    check("b2b_data",    data_o,         8'hFF);

    // Reset during data bit 4 of 0x81 (bits LSB first: 1,0,0,0,0,...).
    v0 = valid_cnt; f0 = ferr_cnt;
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    hold(1'b0, CPB);
    hold(1'b0, CPB);
    hold(1'b0, CPB / 2);
    check("mr_active_pre", active_o, 1'b1);
    rst = 1'b1;
    #1;
    check("mr_data",   data_o,      8'h00);
    check("mr_valid",  valid_o,     1'b0);
    check("mr_ferr",   frame_err_o, 1'b0);
    check("mr_active", active_o,    1'b0);
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 30);
    check("mr_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    send_frame(8'h42, 1'b1, 0);
    hold(1'b1, 40);
    check("mr_valid_n", valid_cnt - v0, 1);
    check("mr_byte",    data_o,         8'h42);

    // Edges moved +/-3 cycles around each bit boundary.
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h96, 1'b1, 3);
    hold(1'b1, 30);
    send_frame(8'h5A, 1'b1, -3);
    hold(1'b1, 40);
    check("jit_valid_n", valid_cnt - v0, 2);
    check("jit_ferr_n",  ferr_cnt - f0,  0);
    check("jit_first",   last_byte(1),   8'h96);
    check("jit_second",  last_byte(0),   8'h5A);

    check("never_both",      both_cnt, 0);
    check("data_only_valid", data_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
